instr_issue_queue: RTL

INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

---
 rtl/issue_pkg.sv | 30 +++
 rtl/issue_fifo.sv | 54 +++++
 rtl/instr_issue_queue.sv | 88 ++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// Shared types and constants for the instruction issue queue.
package issue_pkg;

  localparam int OP_W    = 3;
  localparam int REG_W   = 4;
  localparam int INSTR_W = OP_W + 2 * REG_W;

  localparam logic [OP_W-1:0] OP_SUB    = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD    = 3'd1;
  localparam logic [OP_W-1:0] OP_OR     = 3'd2;
  localparam logic [OP_W-1:0] OP_AND    = 3'd3;
  localparam logic [OP_W-1:0] OP_RSHIFT = 3'd4;
  localparam logic [OP_W-1:0] OP_LSHIFT = 3'd5;
  localparam logic [OP_W-1:0] OP_CMP_LT = 3'd6;
  localparam logic [OP_W-1:0] OP_CMP_EQ = 3'd7;

  // 11-bit instruction word {op, rs, rt}, stored exactly as received
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } instr_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } q_state_e;

endpackage

// File: rtl/issue_fifo.sv
// Instruction storage with wrapping read/write pointers and occupancy count.
module issue_fifo
  import issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  instr_t                 wr_data,
  output instr_t                 rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  instr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage write; contents are never reset, only the pointers matter
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head entry, forced to zero when nothing is queued
  always_comb begin
    rd_data = (count != '0) ? mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/instr_issue_queue.sv
// Issue queue top: producer/execute handshakes, occupancy FSM, result tracking.
module instr_issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [2:0]             in_op,
  input  logic [3:0]             in_rs,
  input  logic [3:0]             in_rt,
  output logic                   in_ready,
  output logic                   ex_valid,
  output logic [2:0]             ex_sel,
  output logic [3:0]             ex_rs,
  output logic [3:0]             ex_rt,
  input  logic                   ex_ready,
  input  logic [3:0]             ex_rd,
  output logic [3:0]             last_rd,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             issued
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  q_state_e state;
  q_state_e state_next;
  logic     push;
  logic     pop;
  instr_t   wr_word;
  instr_t   head;

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_word),
    .rd_data (head),
    .count   (count)
  );

  // Handshake decode; flush blocks both sides
  always_comb begin
    wr_word  = '{op: in_op, rs: in_rs, rt: in_rt};
    in_ready = (state != ST_FULL) && !flush;
    ex_valid = (state != ST_EMPTY);
    push     = in_valid && in_ready;
    pop      = ex_valid && ex_ready && !flush;
    ex_sel   = head.op;
    ex_rs    = head.rs;
    ex_rt    = head.rt;
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  // Occupancy next-state; a simultaneous push and pop holds the state
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_EMPTY;
    end else if (push && !pop) begin
      state_next = (count == FULL_CNT - 1'b1) ? ST_FULL : ST_PARTIAL;
    end else if (pop && !push) begin
      state_next = (count == CNT_W'(1)) ? ST_EMPTY : ST_PARTIAL;
    end
  end

  // Capture the result and bump the issue counter on every pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd <= '0;
      issued  <= '0;
    end else if (pop) begin
      last_rd <= ex_rd;
      issued  <= issued + 8'd1;
    end
  end

endmodule
